// File: rtl/run_ctrl_pkg.sv
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared types and constants for the run controller: FSM state
//               encoding, default bus widths and pushbutton index map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package run_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  // Pushbutton positions inside the packed key vectors
  localparam int KEY_LOAD  = 0;
  localparam int KEY_RUN   = 1;
  localparam int KEY_STEP  = 2;
  localparam int KEY_CLEAR = 3;
  localparam int NUM_KEYS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/run_ctrl_if.sv
// ============================================================================
// Module      : run_ctrl_if
// Description : Instruction-memory and datapath handshake between the run
//               controller (master) and the datapath/memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface run_ctrl_if
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_din;
  logic              im_we;
  logic [ADDR_W-1:0] pc;
  logic              commit;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] next_pc;

  modport master (
    output im_addr, im_din, im_we, pc, commit,
    input  fetch_addr, next_pc
  );

  modport slave (
    input  im_addr, im_din, im_we, pc, commit,
    output fetch_addr, next_pc
  );

endinterface

`default_nettype wire

// File: rtl/key_conditioner.sv
// ============================================================================
// Module      : key_conditioner
// Description : Raw pushbutton -> 2-FF synchroniser -> optional debounce ->
//               registered rising-edge pulse (one cycle per press).
//               Debounce filter present only when DEBOUNCE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_conditioner #(
  parameter int DB_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic key_raw,
  output logic      pulse
);

`ifdef DEBOUNCE_EN
  localparam bit c_DB_BUILD = 1'b1;
`else
  localparam bit c_DB_BUILD = 1'b0;
`endif
  localparam bit c_FILTER = c_DB_BUILD && (DB_CYCLES >= 1);
  localparam int c_CNT_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic r_sync1;
  logic r_sync2;
  logic w_level;
  logic r_prev;
  logic r_pulse;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  if (c_FILTER) begin : g_debounce
    logic               r_db;
    logic [c_CNT_W-1:0] r_cnt;

    // Debounced level follows the synchronised key only after it has
    // differed for DB_CYCLES consecutive cycles; any agreement restarts it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_db  <= 1'b0;
        r_cnt <= '0;
      end else if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_W'(DB_CYCLES - 1)) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_level = r_db;
  end else begin : g_direct
    assign w_level = r_sync2;
  end

  // Registered rising-edge detector: a held key yields a single pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= w_level;
      r_pulse <= w_level & ~r_prev;
    end
  end

  assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/run_controller.sv
// ============================================================================
// Module      : run_controller
// Description : Sequencer for the 8-bit processor. Conditions the four keys,
//               owns pc and the load pointer eom, and shares the single
//               instruction-memory port between the DIP loader and fetch.
//               Key debounce enabled by defining DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DB_CYCLES = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              key_load,
  input  wire logic              key_run,
  input  wire logic              key_step,
  input  wire logic              key_clear,
  input  wire logic [DATA_W-1:0] wr_data,
  run_ctrl_if.master             bus,
  output logic      [ADDR_W-1:0] eom,
  output logic                   running,
  output logic                   done,
  output logic                   full
);

  localparam logic [ADDR_W-1:0] c_EOM_LAST = {ADDR_W{1'b1}} - 1'b1;

  logic [NUM_KEYS-1:0] w_key_raw;
  logic [NUM_KEYS-1:0] w_key_p;

  assign w_key_raw[KEY_LOAD]  = key_load;
  assign w_key_raw[KEY_RUN]   = key_run;
  assign w_key_raw[KEY_STEP]  = key_step;
  assign w_key_raw[KEY_CLEAR] = key_clear;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_conditioner #(.DB_CYCLES(DB_CYCLES)) u_key (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_raw (w_key_raw[gi]),
      .pulse   (w_key_p[gi])
    );
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_eom;
  logic              r_full;
  logic              r_we;
  logic [DATA_W-1:0] r_din;
  logic              w_commit;

  // Coincident pulses resolve clear > load > run > step
  logic w_clr_p, w_load_p, w_run_p, w_step_p;
  assign w_clr_p  = w_key_p[KEY_CLEAR];
  assign w_load_p = w_key_p[KEY_LOAD] & ~w_clr_p;
  assign w_run_p  = w_key_p[KEY_RUN]  & ~w_clr_p & ~w_key_p[KEY_LOAD];
  assign w_step_p = w_key_p[KEY_STEP] & ~w_clr_p & ~w_key_p[KEY_LOAD] & ~w_key_p[KEY_RUN];

  logic w_prog_valid, w_next_in, w_load_acc, w_step_acc;
  assign w_prog_valid = (r_pc < r_eom);
  assign w_next_in    = (bus.next_pc < r_eom);
  assign w_load_acc   = w_load_p & (r_state != RUN) & ~r_full;
  assign w_step_acc   = (r_state == IDLE) & w_step_p & w_prog_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; running off the loaded program ends in DONE
  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_p) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_run_p && w_prog_valid)     w_state_nxt = RUN;
          else if (w_step_acc && !w_next_in) w_state_nxt = DONE;
        end
        RUN: begin
          if (w_run_p)         w_state_nxt = IDLE;
          else if (!w_next_in) w_state_nxt = DONE;
        end
        DONE: begin
          if (w_load_acc) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Commit strobe: every RUN cycle except a pause, or an accepted step
  always_comb begin
    w_commit = 1'b0;
    case (r_state)
      RUN:     w_commit = ~w_run_p & ~w_clr_p;
      IDLE:    w_commit = w_step_acc;
      default: w_commit = 1'b0;
    endcase
  end

  // Program counter advances only on commits that stay inside the program
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_pc <= '0;
    else if (w_clr_p)               r_pc <= '0;
    else if (w_commit && w_next_in) r_pc <= bus.next_pc;
  end

  // Loader: capture on accept, write one cycle later, then bump eom
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_din  <= '0;
      r_eom  <= '0;
      r_full <= 1'b0;
    end else if (w_clr_p) begin
      r_we   <= 1'b0;
      r_eom  <= '0;
      r_full <= 1'b0;
    end else begin
      r_we <= w_load_acc;
      if (w_load_acc) r_din <= wr_data;
      if (r_we) begin
        r_eom  <= r_eom + 1'b1;
        r_full <= (r_eom == c_EOM_LAST);
      end
    end
  end

  assign bus.im_addr = r_we ? r_eom : bus.fetch_addr;
  assign bus.im_din  = r_din;
  assign bus.im_we   = r_we;
  assign bus.pc      = r_pc;
  assign bus.commit  = w_commit;
  assign eom         = r_eom;
  assign running     = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign full        = r_full;

endmodule

`default_nettype wire

// File: tb/tb_run_controller.sv
// ============================================================================
// Module      : tb_run_controller
// Description : Self-checking bench for run_controller. Keys are pressed as
//               a human would; writes and commits are collected from the bus
//               and compared against a program-walk model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_run_controller;
  import run_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DB = 16;
`ifdef DEBOUNCE_EN
  localparam int HOLD   = DB + 4;
  localparam int SETTLE = DB + 6;
`else
  localparam int HOLD   = 3;
  localparam int SETTLE = 6;
`endif
  localparam logic [3:0] M_LOAD  = 4'b0001 << KEY_LOAD;
  localparam logic [3:0] M_RUN   = 4'b0001 << KEY_RUN;
  localparam logic [3:0] M_STEP  = 4'b0001 << KEY_STEP;
  localparam logic [3:0] M_CLEAR = 4'b0001 << KEY_CLEAR;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [3:0]    keys    = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] eom;
  logic          running, done, full;
  logic [AW-1:0] jmp [256];

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0] wq_addr [$];
  logic [DW-1:0] wq_data [$];
  logic [AW-1:0] cq      [$];

  run_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  assign bus.fetch_addr = bus.pc;
  assign bus.next_pc    = jmp[bus.pc];

  run_controller #(.ADDR_W(AW), .DATA_W(DW), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (keys[KEY_LOAD]),
    .key_run   (keys[KEY_RUN]),
    .key_step  (keys[KEY_STEP]),
    .key_clear (keys[KEY_CLEAR]),
    .wr_data   (wr_data),
    .bus       (bus),
    .eom       (eom),
    .running   (running),
    .done      (done),
    .full      (full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.im_we) begin
        wq_addr.push_back(bus.im_addr);
        wq_data.push_back(bus.im_din);
      end
      if (bus.commit) cq.push_back(bus.pc);
    end
  end

  task automatic press(input logic [3:0] m);
    @(negedge clk);
    keys = m;
    repeat (HOLD) @(negedge clk);
    keys = '0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic load_word(input logic [DW-1:0] w);
    wr_data = w;
    press(M_LOAD);
  endtask

  task automatic flush_q();
    wq_addr.delete();
    wq_data.delete();
    cq.delete();
  endtask

  task automatic set_linear();
    for (int p = 0; p < 256; p++) jmp[p] = AW'(p + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.pc !== 8'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", bus.pc); end
    n_cmp++; if (eom !== 8'd0) begin n_err++; $display("FAIL reset_eom: got %0d want 0", eom); end
    n_cmp++; if (bus.im_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", bus.im_we); end
    n_cmp++; if (bus.im_din !== 16'd0) begin n_err++; $display("FAIL reset_din: got %h want 0", bus.im_din); end
    n_cmp++; if (bus.commit !== 1'b0) begin n_err++; $display("FAIL reset_commit: got %b want 0", bus.commit); end
    n_cmp++; if ({running, done, full} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {running, done, full}); end
  endtask

  task automatic test_load_three();
    logic [DW-1:0] w [3];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
    press(M_CLEAR);
    flush_q();
    for (int i = 0; i < 3; i++) load_word(w[i]);
    n_cmp++; if (wq_addr.size() !== 3) begin n_err++; $display("FAIL load3_count: got %0d want 3", wq_addr.size()); end
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      n_cmp++;
      if (wq_addr[i] !== AW'(i) || wq_data[i] !== w[i]) begin
        n_err++; $display("FAIL load3_write%0d: got %0d/%h want %0d/%h", i, wq_addr[i], wq_data[i], i, w[i]);
      end
    end
    n_cmp++; if (eom !== 8'd3) begin n_err++; $display("FAIL load3_eom: got %0d want 3", eom); end
  endtask

  task automatic test_run_linear();
    bit ok = 0;
    set_linear();
    cq.delete();
    press(M_RUN);
    for (int i = 0; i < 600; i++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL run_timeout: done=%b want 1", done); end
    n_cmp++; if (cq.size() !== 3) begin n_err++; $display("FAIL run_commits: got %0d want 3", cq.size()); end
    for (int i = 0; i < 3 && i < cq.size(); i++) begin
      n_cmp++; if (cq[i] !== AW'(i)) begin n_err++; $display("FAIL run_commit_pc%0d: got %0d want %0d", i, cq[i], i); end
    end
    n_cmp++; if (bus.pc !== 8'd2 || running !== 1'b0) begin n_err++; $display("FAIL run_final: pc=%0d running=%b want 2/0", bus.pc, running); end
  endtask

  task automatic test_step_pause();
    int snap;
    press(M_CLEAR);
    for (int i = 0; i < 3; i++) load_word(DW'($urandom));
    set_linear();
    cq.delete();
    press(M_STEP);
    n_cmp++; if (bus.pc !== 8'd1 || cq.size() !== 1) begin n_err++; $display("FAIL step1: pc=%0d commits=%0d want 1/1", bus.pc, cq.size()); end
    press(M_STEP);
    n_cmp++; if (bus.pc !== 8'd2 || cq.size() !== 2) begin n_err++; $display("FAIL step2: pc=%0d commits=%0d want 2/2", bus.pc, cq.size()); end
    n_cmp++; if (running !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL step_state: running=%b done=%b want 0/0", running, done); end
    for (int p = 0; p < 256; p++) jmp[p] = AW'(p);
    press(M_RUN);
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL run_loop: running=%b want 1", running); end
    press(M_RUN);
    snap = cq.size();
    repeat (5) @(negedge clk);
    n_cmp++; if (running !== 1'b0 || done !== 1'b0 || bus.pc !== 8'd2) begin
      n_err++; $display("FAIL pause: running=%b done=%b pc=%0d want 0/0/2", running, done, bus.pc);
    end
    n_cmp++; if (cq.size() !== snap) begin n_err++; $display("FAIL pause_commits: got %0d want %0d", cq.size(), snap); end
  endtask

  task automatic test_load_in_run();
    press(M_RUN);
    flush_q();
    load_word(16'hBEEF);
    n_cmp++; if (wq_addr.size() !== 0 || eom !== 8'd3) begin n_err++; $display("FAIL load_in_run: writes=%0d eom=%0d want 0/3", wq_addr.size(), eom); end
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL load_in_run_state: running=%b want 1", running); end
    press(M_RUN);
  endtask

  task automatic test_clear_load();
    flush_q();
    wr_data = 16'h5A5A;
    press(M_CLEAR | M_LOAD);
    n_cmp++; if (eom !== 8'd0 || bus.pc !== 8'd0 || wq_addr.size() !== 0) begin
      n_err++; $display("FAIL clear_load: eom=%0d pc=%0d writes=%0d want 0/0/0", eom, bus.pc, wq_addr.size());
    end
    press(M_RUN);
    press(M_STEP);
    n_cmp++; if (running !== 1'b0 || cq.size() !== 0) begin n_err++; $display("FAIL empty_run: running=%b commits=%0d want 0/0", running, cq.size()); end
  endtask

  task automatic test_random();
    logic [DW-1:0] words [$];
    logic [AW-1:0] exp_pc [$];
    logic [AW-1:0] p;
    logic [DW-1:0] w;
    int  e;
    int  snap;
    bit  ok;
    for (int it = 0; it < 6; it++) begin
      press(M_CLEAR);
      flush_q();
      words.delete();
      e = int'($urandom_range(1, 12));
      for (int i = 0; i < e; i++) begin
        w = DW'($urandom);
        words.push_back(w);
        load_word(w);
      end
      for (int q = 0; q < 256; q++) jmp[q] = AW'(q + 1 + int'($urandom_range(0, 2)));
      // Walk the program: every visited pc commits; the walk stops at the
      // first successor outside the loaded words
      exp_pc.delete();
      p = '0;
      for (int s = 0; s < 256; s++) begin
        exp_pc.push_back(p);
        if (int'(jmp[p]) < e) p = jmp[p];
        else break;
      end
      press(M_RUN);
      ok = 0;
      for (int i = 0; i < 600; i++) begin
        if (done) begin ok = 1; break; end
        @(negedge clk);
      end
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd%0d_timeout: done=%b want 1", it, done); end
      n_cmp++; if (wq_addr.size() !== e) begin n_err++; $display("FAIL rnd%0d_writes: got %0d want %0d", it, wq_addr.size(), e); end
      for (int i = 0; i < e && i < wq_addr.size(); i++) begin
        n_cmp++;
        if (wq_addr[i] !== AW'(i) || wq_data[i] !== words[i]) begin
          n_err++; $display("FAIL rnd%0d_write%0d: got %0d/%h want %0d/%h", it, i, wq_addr[i], wq_data[i], i, words[i]);
        end
      end
      n_cmp++; if (cq.size() !== exp_pc.size()) begin n_err++; $display("FAIL rnd%0d_commits: got %0d want %0d", it, cq.size(), exp_pc.size()); end
      for (int i = 0; i < exp_pc.size() && i < cq.size(); i++) begin
        n_cmp++; if (cq[i] !== exp_pc[i]) begin n_err++; $display("FAIL rnd%0d_pc%0d: got %0d want %0d", it, i, cq[i], exp_pc[i]); end
      end
      n_cmp++; if (bus.pc !== p) begin n_err++; $display("FAIL rnd%0d_final_pc: got %0d want %0d", it, bus.pc, p); end
      snap = cq.size();
      press(M_RUN);
      press(M_STEP);
      n_cmp++; if (done !== 1'b1 || cq.size() !== snap) begin n_err++; $display("FAIL rnd%0d_done_ignore: done=%b commits=%0d want 1/%0d", it, done, cq.size(), snap); end
      load_word(16'hC0DE);
      n_cmp++; if (done !== 1'b0 || eom !== AW'(e + 1) || wq_addr.size() !== e + 1) begin
        n_err++; $display("FAIL rnd%0d_append: done=%b eom=%0d writes=%0d want 0/%0d/%0d", it, done, eom, wq_addr.size(), e + 1, e + 1);
      end else begin
        n_cmp++; if (wq_addr[e] !== AW'(e)) begin n_err++; $display("FAIL rnd%0d_append_addr: got %0d want %0d", it, wq_addr[e], e); end
      end
    end
  endtask

  task automatic test_full();
    press(M_CLEAR);
    for (int i = 0; i < 255; i++) load_word(DW'(i * 7));
    n_cmp++; if (eom !== 8'd255 || full !== 1'b1) begin n_err++; $display("FAIL full_reach: eom=%0d full=%b want 255/1", eom, full); end
    flush_q();
    load_word(16'hFFFF);
    n_cmp++; if (wq_addr.size() !== 0 || eom !== 8'd255) begin n_err++; $display("FAIL full_block: writes=%0d eom=%0d want 0/255", wq_addr.size(), eom); end
  endtask

  task automatic test_reset_mid_run();
    press(M_CLEAR);
    for (int i = 0; i < 3; i++) load_word(DW'($urandom));
    set_linear();
    jmp[1] = 8'd1;
    press(M_RUN);
    n_cmp++; if (running !== 1'b1 || bus.pc !== 8'd1) begin n_err++; $display("FAIL prerst: running=%b pc=%0d want 1/1", running, bus.pc); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.pc !== 8'd0 || eom !== 8'd0 || bus.im_we !== 1'b0 || running !== 1'b0) begin
      n_err++; $display("FAIL async_rst: pc=%0d eom=%0d we=%b running=%b want 0/0/0/0", bus.pc, eom, bus.im_we, running);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_pulse();
    flush_q();
    wr_data = 16'h0BAD;
    @(negedge clk);
`ifdef DEBOUNCE_EN
    for (int i = 0; i < 5; i++) begin
      keys[KEY_LOAD] = ~keys[KEY_LOAD];
      @(negedge clk);
    end
    keys[KEY_LOAD] = 1'b1;
    repeat (DB + 4) @(negedge clk);
`else
    keys[KEY_LOAD] = 1'b1;
    repeat (20) @(negedge clk);
`endif
    keys = '0;
    repeat (SETTLE) @(negedge clk);
    n_cmp++; if (wq_addr.size() !== 1 || eom !== 8'd1) begin n_err++; $display("FAIL single_pulse: writes=%0d eom=%0d want 1/1", wq_addr.size(), eom); end
  endtask

  initial begin
    set_linear();
    test_reset();
    test_load_three();
    test_run_linear();
    test_step_pause();
    test_load_in_run();
    test_clear_load();
    test_random();
    test_full();
    test_reset_mid_run();
    test_single_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
